// File: rtl/zbt_access_scheduler_if.sv
// -----------------------------------------------------------------------------
// zbt_access_scheduler_if
// Bundles the client-facing and RAM-facing signals of the ZBT access scheduler.
//   slave  : the scheduler itself.
//   master : the environment (display/capture pipelines and the ZBT wrapper).
// Signals:
//   phase                       slot phase 0..3 (scheduler -> environment)
//   disp_addr/disp_data/valid   display read channel
//   cap_valid/ready/x/y/pixel   capture pixel handshake
//   clr_start/busy/done         frame-clear control
//   mem_we/addr/wdata/rdata     ZBT RAM port (2-cycle read latency)
// -----------------------------------------------------------------------------
interface zbt_access_scheduler_if #(
  parameter int ADDR_W = 19
);
  logic [1:0]        phase;
  logic [ADDR_W-1:0] disp_addr;
  logic [35:0]       disp_data;
  logic              disp_valid;
  logic              cap_valid;
  logic              cap_ready;
  logic [9:0]        cap_x;
  logic [9:0]        cap_y;
  logic [7:0]        cap_pixel;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [35:0]       mem_wdata;
  logic [35:0]       mem_rdata;

  modport slave (
    output phase,
    input  disp_addr,
    output disp_data, disp_valid,
    input  cap_valid, cap_x, cap_y, cap_pixel,
    output cap_ready,
    input  clr_start,
    output clr_busy, clr_done,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    input  phase,
    output disp_addr,
    input  disp_data, disp_valid,
    output cap_valid, cap_x, cap_y, cap_pixel,
    input  cap_ready,
    output clr_start,
    input  clr_busy, clr_done,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/zbt_access_scheduler.sv
// -----------------------------------------------------------------------------
// zbt_access_scheduler
// Time-multiplexes one ZBT SRAM port across three clients in a 4-cycle slot:
//   phase 0 : display word read (address taken straight from disp_addr)
//   phase 1 : capture RMW read, or clear write
//   phase 2 : idle (display data returns and is registered)
//   phase 3 : capture RMW write (max-accumulate one lane), or clear write
// Word layout: bits[35:32]=0, lane k = bits[8k+7:8k]; addr = {y, x[9:2]},
// lane = x[1:0].
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    zbt_access_scheduler_if.slave (display, capture, clear, RAM port)
// Configuration:
//   ZBTS_CLEAR_EN  defined   -> frame-clear engine present
//                  undefined -> clr_start ignored, clr_busy/clr_done tied 0
// -----------------------------------------------------------------------------
module zbt_access_scheduler #(
  parameter int                ADDR_W   = 19,
  parameter logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(19'h3FFFF)
) (
  input  logic                    clk,
  input  logic                    reset,
  zbt_access_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_HELD = 2'd1,
    C_RD   = 2'd2
  } cap_state_e;

  cap_state_e        state_q, state_d;
  logic [1:0]        phase_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [1:0]        lane_q;
  logic [7:0]        pixel_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [35:0]       disp_data_q;
  logic              disp_valid_q;

  logic              cap_ready;
  logic              cap_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [35:0]       mem_wdata;
  logic [35:0]       merged;
  logic [7:0]        old_lane;

  // Clear-engine view shared by both builds.
  logic              clr_block;   // clear busy or pending: capture must stay off
  logic              clr_wr;      // clear owns the RAM port this cycle
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_busy;
  logic              clr_done;

  assign cap_fire = bus.cap_valid && cap_ready;

`ifdef ZBTS_CLEAR_EN
  logic              clr_busy_q;
  logic              clr_pend_q;
  logic              clr_done_q;
  logic [ADDR_W-1:0] clr_cnt_q;

  // Clear writes use both odd phases, i.e. two words per slot.
  assign clr_wr    = clr_busy_q && phase_q[0];
  assign clr_addr  = clr_cnt_q;
  assign clr_block = clr_busy_q || clr_pend_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_busy_q <= 1'b0;
      clr_pend_q <= 1'b0;
      clr_done_q <= 1'b0;
      clr_cnt_q  <= '0;
    end else begin
      clr_done_q <= 1'b0;
      if (clr_busy_q) begin
        if (clr_wr) begin
          // The counter stops at CLR_LAST rather than wrapping.
          if (clr_cnt_q == CLR_LAST) begin
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
      end else if (clr_pend_q) begin
        if (state_q == C_IDLE) begin
          clr_busy_q <= 1'b1;
          clr_pend_q <= 1'b0;
          clr_cnt_q  <= '0;
        end
      end else if (bus.clr_start) begin
        // A pixel accepted in this same cycle also owns the port: defer.
        if (state_q != C_IDLE || cap_fire) begin
          clr_pend_q <= 1'b1;
        end else begin
          clr_busy_q <= 1'b1;
          clr_cnt_q  <= '0;
        end
      end
    end
  end
`else
  logic unused_clr;

  assign clr_wr     = 1'b0;
  assign clr_addr   = '0;
  assign clr_block  = 1'b0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign unused_clr = ^{bus.clr_start, CLR_LAST};
`endif

  assign cap_ready = !reset && (state_q == C_IDLE) && !clr_block;

  // Max-accumulate: only the addressed lane may grow; ties keep the old value.
  always_comb begin
    merged   = {4'b0000, bus.mem_rdata[31:0]};
    old_lane = bus.mem_rdata[{lane_q, 3'b000} +: 8];
    if (pixel_q > old_lane) begin
      merged[{lane_q, 3'b000} +: 8] = pixel_q;
    end
  end

  // Slot arbitration and capture FSM next state.
  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_addr  = addr_hold_q;
    mem_wdata = '0;
    unique case (phase_q)
      2'd0: mem_addr = bus.disp_addr;
      2'd1: begin
        if (clr_wr) begin
          mem_we   = 1'b1;
          mem_addr = clr_addr;
        end else if (state_q == C_HELD) begin
          mem_addr = cap_addr_q;
          state_d  = C_RD;
        end
      end
      2'd3: begin
        if (clr_wr) begin
          mem_we   = 1'b1;
          mem_addr = clr_addr;
        end else if (state_q == C_RD) begin
          // Read issued in phase 1 returns now; write back in the same cycle.
          mem_we    = 1'b1;
          mem_addr  = cap_addr_q;
          mem_wdata = merged;
          state_d   = C_IDLE;
        end
      end
      default: ;
    endcase
    if (state_q == C_IDLE && cap_fire) begin
      state_d = C_HELD;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= 2'd0;
      state_q      <= C_IDLE;
      cap_addr_q   <= '0;
      lane_q       <= 2'd0;
      pixel_q      <= 8'd0;
      addr_hold_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_q + 2'd1;
      state_q      <= state_d;
      addr_hold_q  <= mem_addr;
      disp_valid_q <= (phase_q == 2'd2);
      if (phase_q == 2'd2) begin
        disp_data_q <= bus.mem_rdata;
      end
      if (cap_fire) begin
        cap_addr_q <= ADDR_W'({bus.cap_y, bus.cap_x[9:2]});
        lane_q     <= bus.cap_x[1:0];
        pixel_q    <= bus.cap_pixel;
      end
    end
  end

  assign bus.phase      = phase_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.cap_ready  = cap_ready;
  assign bus.clr_busy   = clr_busy;
  assign bus.clr_done   = clr_done;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_zbt_access_scheduler.sv
// -----------------------------------------------------------------------------
// tb_zbt_access_scheduler
// Scoreboard bench: directed stimulus pushes expected RAM writes and display
// words into queues; a negedge monitor pops and compares whenever the DUT
// writes RAM or pulses disp_valid. A behavioural ZBT model (2-cycle read
// latency) backs the RAM port. Clear-engine checks follow ZBTS_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_zbt_access_scheduler;

  localparam int                ADDR_W   = 19;
  localparam logic [ADDR_W-1:0] CLR_LAST = 19'd7;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [35:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  zbt_access_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  zbt_access_scheduler #(
    .ADDR_W  (ADDR_W),
    .CLR_LAST(CLR_LAST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  wr_t         exp_wr_q[$];
  logic [35:0] exp_disp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired waiting for DUT", name);
  endtask

  // ZBT model: read data appears two cycles after its address.
  logic [35:0] mem_model [logic [ADDR_W-1:0]];
  logic [35:0] rd1 = '0;
  logic [35:0] rd2 = '0;
  assign bus.mem_rdata = rd2;

  function automatic logic [35:0] mem_peek(input logic [ADDR_W-1:0] a);
    return mem_model.exists(a) ? mem_model[a] : 36'h0;
  endfunction

  always @(posedge clk) begin
    rd1 <= mem_peek(bus.mem_addr);
    rd2 <= rd1;
    if (bus.mem_we === 1'b1) mem_model[bus.mem_addr] = bus.mem_wdata;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        check("wr_data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
    if (bus.disp_valid === 1'b1 && exp_disp_q.size() != 0) begin
      logic [35:0] d;
      d = exp_disp_q.pop_front();
      check("disp_data", 64'(bus.disp_data), 64'(d));
      check("disp_phase", 64'(bus.phase), 64'd3);
    end
  end

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [35:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr_q.push_back(e);
  endtask

  task automatic wait_phase(input logic [1:0] p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.phase !== p && n < 8);
    if (bus.phase !== p) timeout("wait_phase");
  endtask

  task automatic do_capture(input logic [9:0] x, input logic [9:0] y, input logic [7:0] pix,
                            input logic [ADDR_W-1:0] ea, input logic [35:0] ed);
    int n;
    push_wr(ea, ed);
    @(negedge clk);
    bus.cap_valid = 1'b1;
    bus.cap_x     = x;
    bus.cap_y     = y;
    bus.cap_pixel = pix;
    n = 0;
    while (bus.cap_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout("cap_handshake");
    @(negedge clk);
    bus.cap_valid = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge clk);
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
  endtask

`ifdef ZBTS_CLEAR_EN
  // Runs until clr_done has pulsed and settled; reports handshake behaviour.
  task automatic watch_clear(output int done_cnt, output int ready_bad,
                             output int first_wr, output int last_wr);
    int n;
    int settle;
    done_cnt  = 0;
    ready_bad = 0;
    first_wr  = -1;
    last_wr   = -1;
    settle    = 0;
    n         = 0;
    while (settle < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (bus.clr_busy === 1'b1 && bus.cap_ready !== 1'b0) ready_bad++;
      if (bus.clr_done === 1'b1) done_cnt++;
      if (bus.mem_we === 1'b1) begin
        if (first_wr < 0) first_wr = n;
        last_wr = n;
      end
      if (done_cnt != 0) settle++;
    end
    if (n >= 80) timeout("clear_done");
  endtask
`endif

  initial begin
    int done_cnt, ready_bad, first_wr, last_wr, n, bad;
    bus.disp_addr = '0;
    bus.cap_valid = 1'b0;
    bus.cap_x     = '0;
    bus.cap_y     = '0;
    bus.cap_pixel = '0;
    bus.clr_start = 1'b0;
    reset         = 1'b1;
    mem_model[19'h00301] = 36'h0_10203040;
    mem_model[19'h00001] = 36'h0_11223340;
    mem_model[19'h00123] = 36'hA_BCDEF012;

    // Reset held for three edges: everything quiet.
    repeat (3) @(negedge clk);
    check("rst_phase", 64'(bus.phase), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_disp_data", 64'(bus.disp_data), 64'd0);
    check("rst_disp_valid", 64'(bus.disp_valid), 64'd0);
    check("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
    check("rst_clr_done", 64'(bus.clr_done), 64'd0);
    check("rst_cap_ready", 64'(bus.cap_ready), 64'd0);

    reset = 1'b0;
    #1;
    check("rel_cap_ready", 64'(bus.cap_ready), 64'd1);
    check("rel_phase0", 64'(bus.phase), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("phase_seq", 64'(bus.phase), 64'(i % 4));
    end

    // Capture RMW: lane grows, then lane kept on a smaller pixel.
    do_capture(10'd5, 10'd3, 8'h80, 19'h00301, 36'h0_10208040);
    do_capture(10'd4, 10'd0, 8'h20, 19'h00001, 36'h0_11223340);
    repeat (12) @(negedge clk);
    check("cap_writes_left", 64'(exp_wr_q.size()), 64'd0);

    // Display read.
    wait_phase(2'd3);
    bus.disp_addr = 19'h00123;
    @(negedge clk);
    exp_disp_q.push_back(36'hA_BCDEF012);
    wait_phase(2'd3);
    @(negedge clk);
    check("disp_valid_width", 64'(bus.disp_valid), 64'd0);
    check("disp_hold", 64'(bus.disp_data), 64'hA_BCDEF012);
    check("disp_left", 64'(exp_disp_q.size()), 64'd0);

`ifdef ZBTS_CLEAR_EN
    // Full clear of addresses 0..CLR_LAST.
    for (int a = 0; a <= 7; a++) push_wr(19'(a), 36'h0);
    pulse_clr;
    watch_clear(done_cnt, ready_bad, first_wr, last_wr);
    check("clr_writes_left", 64'(exp_wr_q.size()), 64'd0);
    check("clr_done_pulses", 64'(done_cnt), 64'd1);
    check("clr_cap_ready_low", 64'(ready_bad), 64'd0);
    check("clr_write_span", 64'(last_wr - first_wr), 64'd14);
    check("clr_busy_after", 64'(bus.clr_busy), 64'd0);

    // Reset right after the write to address 3 aborts the sweep.
    for (int a = 0; a <= 3; a++) push_wr(19'(a), 36'h0);
    pulse_clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_we === 1'b1 && bus.mem_addr == 19'd3) && n < 40);
    if (n >= 40) timeout("clr_addr3");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_clr_busy", 64'(bus.clr_busy), 64'd0);
    repeat (8) @(negedge clk);
    check("abort_writes_left", 64'(exp_wr_q.size()), 64'd0);

    // A fresh sweep starts again from address 0.
    for (int a = 0; a <= 7; a++) push_wr(19'(a), 36'h0);
    pulse_clr;
    watch_clear(done_cnt, ready_bad, first_wr, last_wr);
    check("restart_writes_left", 64'(exp_wr_q.size()), 64'd0);
    check("restart_done_pulses", 64'(done_cnt), 64'd1);
`else
    // Without the clear engine clr_start has no effect.
    pulse_clr;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) bad++;
    end
    check("noclr_flags", 64'(bad), 64'd0);
    check("noclr_cap_ready", 64'(bus.cap_ready), 64'd1);
    check("noclr_writes_left", 64'(exp_wr_q.size()), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
